// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings for the data-memory controller.
// Holds the access-size codes, the controller FSM states and the byte-lane masks.
package dmem_pkg;

    // Access size codes as carried on req_size; 2'b11 is not a legal size.
    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    // Byte-lane masks for an access at offset 0.
    localparam logic [3:0] LANE_B = 4'h1;
    localparam logic [3:0] LANE_H = 4'h3;
    localparam logic [3:0] LANE_W = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Lane mask for a size code before it is shifted by the byte offset.
    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            SIZE_B:  size_mask = LANE_B;
            SIZE_H:  size_mask = LANE_H;
            default: size_mask = LANE_W;
        endcase
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// dmem_bank: MEM_WORDS x 32 storage with per-byte write enables.
// Writes happen on the rising edge; the read port is combinational.
// The contents are never reset.
module dmem_bank #(
    parameter int MEM_WORDS = 1024
) (
    input  logic                         clk,
    input  logic [3:0]                   we,
    input  logic [$clog2(MEM_WORDS)-1:0] addr,
    input  logic [31:0]                  wdata,
    output logic [31:0]                  rdata
);

    logic [31:0] mem [MEM_WORDS];

    // Byte-lane write: only lanes with their enable set are updated.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: single-outstanding data-memory controller.
// It handles byte, half and word loads and stores, with optional wait states.
// Define DMEM_BOUNDS_CHECK_EN to flag addresses beyond MEM_WORDS as errors.
// Without that macro, the upper address bits are ignored and accesses wrap.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [3:0] WS_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_e      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic        enter_resp;
    logic        accept;

    logic        we_reg, uns_reg;
    logic [1:0]  size_reg;
    logic [31:0] addr_reg, wdata_reg;

    logic        op_we, op_uns;
    logic [1:0]  op_size;
    logic [31:0] op_addr, op_wdata;

    logic        misalign, out_of_range, op_err;
    logic [3:0]  lane_mask, bank_we;
    logic [31:0] bank_wdata, bank_rdata, shifted, load_data;

    assign req_ready = (state_reg == IDLE);
    assign rsp_valid = (state_reg == RESP);
    assign accept    = req_valid && req_ready;

    // State register and wait counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic; enter_resp marks the edge on which memory is accessed.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        enter_resp = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (WAIT_STATES > 0) begin
                        state_next = WAIT;
                        cnt_next   = 4'd0;
                    end else begin
                        state_next = RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_reg == WS_LAST) begin
                    state_next = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Capture the request fields on accept; they are held while the access is in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_reg    <= 1'b0;
            uns_reg   <= 1'b0;
            size_reg  <= SIZE_W;
            addr_reg  <= 32'd0;
            wdata_reg <= 32'd0;
        end else if (accept) begin
            we_reg    <= req_we;
            uns_reg   <= req_unsigned;
            size_reg  <= req_size;
            addr_reg  <= req_addr;
            wdata_reg <= req_wdata;
        end
    end

    // Operand selection.
    // With zero wait states, the access happens on the accept edge itself.
    // At that point the captured copies are not yet loaded, so the live inputs are used.
    always_comb begin
        if (state_reg == IDLE) begin
            op_we    = req_we;
            op_uns   = req_unsigned;
            op_size  = req_size;
            op_addr  = req_addr;
            op_wdata = req_wdata;
        end else begin
            op_we    = we_reg;
            op_uns   = uns_reg;
            op_size  = size_reg;
            op_addr  = addr_reg;
            op_wdata = wdata_reg;
        end
    end

    assign misalign = (op_size == 2'b11)
                   || ((op_size == SIZE_H) && op_addr[0])
                   || ((op_size == SIZE_W) && (op_addr[1:0] != 2'b00));

`ifdef DMEM_BOUNDS_CHECK_EN
    assign out_of_range = (op_addr[31:2] >= 30'(MEM_WORDS));
`else
    // Upper address bits deliberately do not take part: accesses wrap modulo MEM_WORDS.
    logic unused_addr_hi;
    assign unused_addr_hi = &{1'b0, op_addr[31:AW+2]};
    assign out_of_range   = 1'b0;
`endif

    assign op_err    = misalign || out_of_range;
    assign lane_mask = 4'(size_mask(op_size) << op_addr[1:0]);
    assign bank_we   = (enter_resp && op_we && !op_err) ? lane_mask : 4'h0;

    // Replicate store data so the selected lanes see the LSB-aligned value wherever they sit.
    always_comb begin
        case (op_size)
            SIZE_B:  bank_wdata = {4{op_wdata[7:0]}};
            SIZE_H:  bank_wdata = {2{op_wdata[15:0]}};
            default: bank_wdata = op_wdata;
        endcase
    end

    dmem_bank #(.MEM_WORDS(MEM_WORDS)) u_bank (
        .clk   (clk),
        .we    (bank_we),
        .addr  (op_addr[AW+1:2]),
        .wdata (bank_wdata),
        .rdata (bank_rdata)
    );

    // Load alignment and extension: bring the addressed lanes to bit 0, then extend.
    always_comb begin
        shifted = bank_rdata >> {op_addr[1:0], 3'b000};
        case (op_size)
            SIZE_B:  load_data = {{24{~op_uns & shifted[7]}}, shifted[7:0]};
            SIZE_H:  load_data = {{16{~op_uns & shifted[15]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    // Response registers: loaded on the RESP-entry edge and held until the next response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else if (enter_resp) begin
            rsp_rdata <= (op_err || op_we) ? 32'd0 : load_data;
            rsp_err   <= op_err;
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed plus randomized bench for dmem_ctrl.
// It drives two instances, both with MEM_WORDS=64: index 0 has WAIT_STATES=0, index 1 has WAIT_STATES=3.
// The reference model for instance 0 is a plain byte array.
// Define DMEM_BOUNDS_CHECK_EN to build the bounds-checking variant.
module tb_dmem_ctrl;

`ifdef DMEM_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif
    localparam int WORDS = 64;
    localparam int BYTES = WORDS * 4;

    logic        clk = 1'b0;
    logic        reset     [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [1:0]  req_size  [2];
    logic        req_uns   [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic        rsp_valid [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] ref_mem   [BYTES];
    bit         ref_known [BYTES];

    always #5 clk = ~clk;

    dmem_ctrl #(.MEM_WORDS(WORDS), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_size(req_size[0]), .req_unsigned(req_uns[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

    dmem_ctrl #(.MEM_WORDS(WORDS), .WAIT_STATES(3)) dut3 (
        .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_size(req_size[1]), .req_unsigned(req_uns[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // One transaction: wait for ready, present the request for the accept edge,
    // then count negedges until the response pulse (lat = cycles after accept).
    task automatic op(input int d, input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic err, output int lat);
        int waited = 0;
        rdata = 'x;
        err   = 'x;
        lat   = -1;
        @(negedge clk);
        while (!req_ready[d] && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_size[d]  = size;
        req_uns[d]   = uns;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        @(posedge clk);
        #1 req_valid[d] = 1'b0;
        req_addr[d]  = $urandom;
        req_wdata[d] = $urandom;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (rsp_valid[d]) begin
                lat   = k;
                rdata = rsp_rdata[d];
                err   = rsp_err[d];
                break;
            end
        end
        $display("op d%0d we=%0d size=%0d uns=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
                 d, we, size, uns, addr, wdata, rdata, err, lat);
    endtask

    // Reference behaviour for instance 0, derived from byte-addressed memory semantics.
    task automatic model_op(input logic we, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] er, output logic ee, output bit known);
        int nb;
        int base;
        logic [31:0] v;
        nb    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        ee    = (size == 2'd3) || ((addr % nb) != 0);
        if (BOUNDS && ((addr >> 2) >= WORDS)) ee = 1'b1;
        er    = 32'd0;
        known = 1'b1;
        if (ee) return;
        base = int'(addr % BYTES);
        if (we) begin
            for (int i = 0; i < nb; i++) begin
                ref_mem[base + i]   = wdata[8*i +: 8];
                ref_known[base + i] = 1'b1;
            end
        end else begin
            v = 32'd0;
            for (int i = 0; i < nb; i++) begin
                if (!ref_known[base + i]) known = 1'b0;
                v = v | (32'(ref_mem[base + i]) << (8*i));
            end
            if (!uns && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8*nb)) - 32'd1);
            er = v;
        end
    endtask

    // Directed transaction on instance 0 against constant expectations; also updates the model.
    task automatic dop(input string tag, input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err);
        logic [31:0] r, mr;
        logic e, me;
        int lat;
        bit kn;
        op(0, we, size, uns, addr, wdata, r, e, lat);
        model_op(we, size, uns, addr, wdata, mr, me, kn);
        check({tag, "_lat"}, 32'(lat), 32'd1);
        check({tag, "_rdata"}, r, exp_rdata);
        check({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
    endtask

    initial begin
        logic [31:0] r, mr, wd, ad;
        logic e, me;
        logic [1:0] sz;
        logic we_b, un_b;
        int lat;
        bit kn;
        logic [9:0] rv_bits, rdy_bits;

        for (int d = 0; d < 2; d++) begin
            reset[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_size[d] = 2'd0;
            req_uns[d] = 1'b0; req_addr[d] = 32'd0; req_wdata[d] = 32'd0;
        end
        for (int i = 0; i < BYTES; i++) ref_known[i] = 1'b0;

        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("reset_ready", {31'd0, req_ready[d]}, 32'd1);
            check("reset_rsp_valid", {31'd0, rsp_valid[d]}, 32'd0);
            check("reset_rdata", rsp_rdata[d], 32'd0);
            check("reset_err", {31'd0, rsp_err[d]}, 32'd0);
        end
        reset[0] = 1'b0;
        reset[1] = 1'b0;

        // Word store/load, then byte merge with signed and unsigned reloads.
        dop("sw_10", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        dop("lw_10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        check("rdata_held", rsp_rdata[0], 32'hDEADBEEF);
        dop("sb_12", 1'b1, 2'd0, 1'b0, 32'h12, 32'h0000007F, 32'h0, 1'b0);
        dop("lb_12", 1'b0, 2'd0, 1'b0, 32'h12, 32'h0, 32'h0000007F, 1'b0);
        dop("lw_10b", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDE7FBEEF, 1'b0);
        dop("lh_12", 1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 32'hFFFFDE7F, 1'b0);
        dop("lhu_12", 1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 32'h0000DE7F, 1'b0);
        dop("lbu_13", 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 32'h000000DE, 1'b0);
        dop("lb_13", 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0);

        // Errors: misaligned store leaves memory intact, misaligned half, illegal size.
        dop("sw_20", 1'b1, 2'd2, 1'b0, 32'h20, 32'hA5A55A5A, 32'h0, 1'b0);
        dop("sw_22_err", 1'b1, 2'd2, 1'b0, 32'h22, 32'h11223344, 32'h0, 1'b1);
        dop("lw_20", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'hA5A55A5A, 1'b0);
        dop("lh_13_err", 1'b0, 2'd1, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1);
        dop("size3_err", 1'b0, 2'd3, 1'b0, 32'h20, 32'h0, 32'h0, 1'b1);
        dop("sh_22", 1'b1, 2'd1, 1'b0, 32'h22, 32'h0000BEEF, 32'h0, 1'b0);
        dop("lw_20c", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'hBEEF5A5A, 1'b0);

        // Out-of-range word: error with bounds checking, wraps to word 0 without it.
        dop("sw_00", 1'b1, 2'd2, 1'b0, 32'h0, 32'h0BADF00D, 32'h0, 1'b0);
        if (BOUNDS) dop("lw_100", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1);
        else        dop("lw_100", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'h0BADF00D, 1'b0);

        // Randomized traffic on instance 0 against the byte-array model.
        for (int n = 0; n < 80; n++) begin
            we_b = 1'($urandom_range(0, 1));
            un_b = 1'($urandom_range(0, 1));
            sz   = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            ad   = 32'($urandom_range(0, 2*BYTES - 1));
            if ($urandom_range(0, 3) != 0) ad = ad & ~32'((sz == 2'd2) ? 3 : (sz == 2'd1) ? 1 : 0);
            wd   = $urandom;
            op(0, we_b, sz, un_b, ad, wd, r, e, lat);
            model_op(we_b, sz, un_b, ad, wd, mr, me, kn);
            check("rnd_lat", 32'(lat), 32'd1);
            check("rnd_err", {31'd0, e}, {31'd0, me});
            if (kn) check("rnd_rdata", r, mr);
        end

        // Wait-state timing with req_valid held high on instance 1.
        @(negedge clk);
        req_valid[1] = 1'b1; req_we[1] = 1'b0; req_size[1] = 2'd2; req_uns[1] = 1'b0;
        req_addr[1] = 32'h40;
        @(posedge clk);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            rv_bits[c-1]  = rsp_valid[1];
            rdy_bits[c-1] = req_ready[1];
        end
        req_valid[1] = 1'b0;
        $display("ws3 held valid: rsp_valid=%b ready=%b", rv_bits, rdy_bits);
        check("ws3_rsp_valid_pattern", 32'(rv_bits), 32'(10'b0100001000));
        check("ws3_ready_pattern", 32'(rdy_bits), 32'(10'b1000010000));

        // Reset during an in-flight store drops it.
        op(1, 1'b1, 2'd2, 1'b0, 32'h40, 32'h12345678, r, e, lat);
        check("ws3_sw_lat", 32'(lat), 32'd4);
        op(1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, r, e, lat);
        check("ws3_lw_lat", 32'(lat), 32'd4);
        check("ws3_lw_rdata", r, 32'h12345678);
        @(negedge clk);
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_size[1] = 2'd2; req_addr[1] = 32'h40;
        req_wdata[1] = 32'hCAFEF00D;
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset[1] = 1'b1;
        #1;
        check("rst_ready", {31'd0, req_ready[1]}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid[1]}, 32'd0);
        check("rst_rdata", rsp_rdata[1], 32'd0);
        check("rst_err", {31'd0, rsp_err[1]}, 32'd0);
        #1 reset[1] = 1'b0;
        rv_bits = '0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (rsp_valid[1]) rv_bits[c] = 1'b1;
        end
        $display("after reset pulse: rsp_valid seen=%b", rv_bits);
        check("rst_no_rsp", 32'(rv_bits), 32'd0);
        op(1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, r, e, lat);
        check("rst_lw_lat", 32'(lat), 32'd4);
        check("rst_lw_rdata", r, 32'h12345678);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
